// File: rtl/spi_arb_pkg.sv
// spi_arb_pkg: shared state encoding and error word for spi_arbiter
package spi_arb_pkg;
    typedef enum logic [1:0] {IDLE, ISSUE, WAIT, RESP} state_t;
    // Returned in place of a received word when the WAIT watchdog expires.
    localparam logic [63:0] ERR_WORD = '1;
endpackage

// File: rtl/spi_arbiter_rr_picker.sv
// spi_arbiter_rr_picker: first requester at or above ptr, with wrap
// Ports: req (request vector), ptr (search start), grant (winning index), any (some request set)
module spi_arbiter_rr_picker #(
    parameter int requester_count = 4
) (
    input  logic [requester_count-1:0]         req,
    input  logic [$clog2(requester_count)-1:0] ptr,
    output logic [$clog2(requester_count)-1:0] grant,
    output logic                               any
);
    localparam int IW = $clog2(requester_count);

    // Scan from the farthest offset down so the nearest request overwrites last.
    always_comb begin
        grant = '0;
        any = |req;
        for (int k = requester_count - 1; k >= 0; k--)
            if (req[(int'(ptr) + k) % requester_count])
                grant = IW'((int'(ptr) + k) % requester_count);
    end
endmodule

// File: rtl/spi_arbiter.sv
// spi_arbiter: round-robin sharing of one SPI master among several requesters
// Ports: req_* (per-requester word, slave-select, burst end, accept strobe),
//        rsp_* (one-hot response strobe, received word, timeout flag),
//        spi_* (start/tx/ss to the SPI core, done/rx back from it).
// Build option: SPI_ARB_TIMEOUT_EN adds a WAIT watchdog of timeout_cycles.
module spi_arbiter
    import spi_arb_pkg::*;
#(
    parameter int requester_count = 4,
    parameter int word_width      = 8,
    parameter int SS_width        = 1,
    parameter int timeout_cycles  = 255
) (
    input  logic                                  clk,
    input  logic                                  rst,
    input  logic [requester_count-1:0]            req_valid,
    input  logic [requester_count*word_width-1:0] req_data,
    input  logic [requester_count*SS_width-1:0]   req_ss,
    input  logic [requester_count-1:0]            req_last,
    output logic [requester_count-1:0]            req_ready,
    output logic [requester_count-1:0]            rsp_valid,
    output logic [word_width-1:0]                 rsp_data,
    output logic                                  rsp_err,
    output logic                                  spi_start,
    output logic [word_width-1:0]                 spi_tx,
    output logic [SS_width-1:0]                   spi_ss,
    input  logic                                  spi_done,
    input  logic [word_width-1:0]                 spi_rx
);
    localparam int IW = $clog2(requester_count);

    if (requester_count < 2 || timeout_cycles < 1) begin : g_bad_param
        $error("spi_arbiter: requester_count must be >= 2 and timeout_cycles >= 1");
    end

    state_t                     state_q, state_d;
    logic [IW-1:0]              g_q, g_d, p_q, p_d, pick;
    logic                       lock_q, lock_d, any;
    logic [SS_width-1:0]        ss_q, ss_d;
    logic [word_width-1:0]      rx_q, rx_d;
    logic [requester_count-1:0] g_oh;

    spi_arbiter_rr_picker #(.requester_count(requester_count)) u_picker (
        .req   (req_valid),
        .ptr   (p_q),
        .grant (pick),
        .any   (any)
    );

    assign g_oh      = {{(requester_count-1){1'b0}}, 1'b1} << g_q;
    assign req_ready = (state_q == ISSUE) ? g_oh : '0;
    assign rsp_valid = (state_q == RESP) ? g_oh : '0;
    assign spi_start = state_q == ISSUE;
    assign spi_tx    = req_data[int'(g_q)*word_width +: word_width];
    assign spi_ss    = ss_q;
    assign rsp_data  = rx_q;

`ifdef SPI_ARB_TIMEOUT_EN
    localparam int CW = $clog2(timeout_cycles + 1);
    logic [CW-1:0] cnt_q, cnt_d;
    logic          err_q, err_d;
    assign rsp_err = err_q;

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            cnt_q <= '0;
            err_q <= 1'b0;
        end else begin
            cnt_q <= cnt_d;
            err_q <= err_d;
        end
`else
    assign rsp_err = 1'b0;
`endif

    always_comb begin
        state_d = state_q;
        g_d     = g_q;
        p_d     = p_q;
        lock_d  = lock_q;
        ss_d    = ss_q;
        rx_d    = rx_q;
`ifdef SPI_ARB_TIMEOUT_EN
        cnt_d   = cnt_q;
        err_d   = err_q;
`endif
        case (state_q)
            // A held grant ignores everyone else until its burst ends.
            IDLE: if (lock_q ? req_valid[g_q] : any) begin
                g_d     = lock_q ? g_q : pick;
                state_d = ISSUE;
            end
            ISSUE: begin
                ss_d    = req_ss[int'(g_q)*SS_width +: SS_width];
                lock_d  = ~req_last[g_q];
                state_d = WAIT;
`ifdef SPI_ARB_TIMEOUT_EN
                cnt_d   = '0;
`endif
            end
            WAIT: if (spi_done) begin
                rx_d    = spi_rx;
                state_d = RESP;
`ifdef SPI_ARB_TIMEOUT_EN
                err_d   = 1'b0;
            end else if (cnt_q == CW'(timeout_cycles)) begin
                rx_d    = ERR_WORD[word_width-1:0];
                err_d   = 1'b1;
                lock_d  = 1'b0;
                state_d = RESP;
            end else begin
                cnt_d   = cnt_q + 1'b1;
`endif
            end
            RESP: begin
                p_d     = lock_q ? p_q : (g_q == IW'(requester_count - 1)) ? '0 : g_q + 1'b1;
                state_d = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst)
        if (rst) begin
            state_q <= IDLE;
            g_q     <= '0;
            p_q     <= '0;
            lock_q  <= 1'b0;
            ss_q    <= '0;
            rx_q    <= '0;
        end else begin
            state_q <= state_d;
            g_q     <= g_d;
            p_q     <= p_d;
            lock_q  <= lock_d;
            ss_q    <= ss_d;
            rx_q    <= rx_d;
        end
endmodule

// File: tb/tb_spi_arbiter.sv
// tb_spi_arbiter: directed self-checking bench for spi_arbiter
module tb_spi_arbiter;
    localparam int N = 4;
    localparam int W = 8;
    localparam int S = 2;
`ifdef SPI_ARB_TIMEOUT_EN
    localparam int TO = 8;
`else
    localparam int TO = 255;
`endif

    logic         clk = 1'b0;
    logic         rst = 1'b1;
    logic [N-1:0] req_valid = '0;
    logic [N*W-1:0] req_data = '0;
    logic [N*S-1:0] req_ss = {2'd3, 2'd2, 2'd1, 2'd0};
    logic [N-1:0] req_last = '1;
    logic [N-1:0] req_ready, rsp_valid;
    logic [W-1:0] rsp_data, spi_tx, spi_rx = '0;
    logic         rsp_err, spi_start, spi_done = 1'b0;
    logic [S-1:0] spi_ss;

    int checks = 0;
    int failures = 0;

    always #5 clk = ~clk;

    spi_arbiter #(
        .requester_count (N),
        .word_width      (W),
        .SS_width        (S),
        .timeout_cycles  (TO)
    ) dut (
        .clk       (clk),
        .rst       (rst),
        .req_valid (req_valid),
        .req_data  (req_data),
        .req_ss    (req_ss),
        .req_last  (req_last),
        .req_ready (req_ready),
        .rsp_valid (rsp_valid),
        .rsp_data  (rsp_data),
        .rsp_err   (rsp_err),
        .spi_start (spi_start),
        .spi_tx    (spi_tx),
        .spi_ss    (spi_ss),
        .spi_done  (spi_done),
        .spi_rx    (spi_rx)
    );

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    function automatic int onehot_idx(input logic [N-1:0] oh);
        onehot_idx = -1;
        if ($onehot(oh))
            for (int i = 0; i < N; i++)
                if (oh[i]) onehot_idx = i;
    endfunction

    task automatic do_reset();
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0;
    endtask

    // Acts as the SPI core for one word: finds the ISSUE cycle, answers after lat cycles, checks the response.
    task automatic serve(input int lat, input logic [W-1:0] rx, output int who,
                         output logic [W-1:0] tx, output logic [S-1:0] ss);
        int n = 0;
        logic [N-1:0] rdy;
        while (!spi_start && n < 50) begin
            @(negedge clk);
            n++;
        end
        check("start_seen", 32'(n < 50), 1);
        rdy = req_ready;
        who = onehot_idx(rdy);
        tx  = spi_tx;
        @(negedge clk);
        ss = spi_ss;
        check("start_one_cycle", 32'(spi_start), 0);
        repeat (lat - 1) @(negedge clk);
        spi_done = 1'b1;
        spi_rx   = rx;
        @(negedge clk);
        spi_done = 1'b0;
        check("rsp_valid", 32'(rsp_valid), 32'(rdy));
        check("rsp_data", 32'(rsp_data), 32'(rx));
        check("rsp_err", 32'(rsp_err), 0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int who, n, seen;
        logic [W-1:0] tx;
        logic [S-1:0] ss;
        repeat (2) @(negedge clk);
        rst = 1'b0;
        check("rst_ready", 32'(req_ready), 0);
        check("rst_rsp_valid", 32'(rsp_valid), 0);
        check("rst_start", 32'(spi_start), 0);
        check("rst_ss", 32'(spi_ss), 0);
        check("rst_rsp_data", 32'(rsp_data), 0);
        check("rst_rsp_err", 32'(rsp_err), 0);

        req_data[7:0] = 8'hA5;
        req_valid = 4'b0001;
        @(negedge clk);
        check("single_start_c1", 32'(spi_start), 1);
        check("single_ready", 32'(req_ready), 'b0001);
        check("single_tx", 32'(spi_tx), 'hA5);
        serve(5, 8'h3C, who, tx, ss);
        check("single_who", 32'(who), 0);
        req_data[15:8] = 8'h11;
        req_valid = 4'b0011;
        serve(2, 8'h5A, who, tx, ss);
        check("ptr_after_single", 32'(who), 1);
        check("ptr_after_single_tx", 32'(tx), 'h11);
        check("ptr_after_single_ss", 32'(ss), 1);

        req_valid = '0;
        do_reset();
        req_data  = {8'h13, 8'h12, 8'h11, 8'h10};
        req_valid = 4'hF;
        for (int k = 0; k < 5; k++) begin
            serve(1 + k, W'(8'h80 + k), who, tx, ss);
            check("rr_who", 32'(who), 32'(k % 4));
            check("rr_tx", 32'(tx), 32'('h10 + k % 4));
            check("rr_ss", 32'(ss), 32'(k % 4));
        end
        req_valid = '0;

        do_reset();
        req_data[23:16] = 8'h20;
        req_last  = 4'b1011;
        req_valid = 4'b0100;
        serve(3, 8'h61, who, tx, ss);
        check("burst0_who", 32'(who), 2);
        check("burst0_ss", 32'(ss), 2);
        req_data[23:16] = 8'h21;
        req_valid = 4'b0101;
        serve(2, 8'h62, who, tx, ss);
        check("burst1_who", 32'(who), 2);
        check("burst1_tx", 32'(tx), 'h21);
        check("burst1_ss", 32'(ss), 2);
        req_data[23:16] = 8'h22;
        req_last = 4'b1111;
        serve(1, 8'h63, who, tx, ss);
        check("burst2_who", 32'(who), 2);
        check("burst2_tx", 32'(tx), 'h22);
        check("burst2_ss", 32'(ss), 2);
        req_valid = 4'b0001;
        serve(2, 8'h64, who, tx, ss);
        check("after_burst_who", 32'(who), 0);
        check("after_burst_ss", 32'(ss), 0);
        req_valid = '0;

        req_valid = 4'b0010;
        n = 0;
        while (!spi_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        check("midwait_who", 32'(onehot_idx(req_ready)), 1);
        @(negedge clk);
        rst = 1'b1;
        @(negedge clk);
        check("midwait_start", 32'(spi_start), 0);
        check("midwait_ready", 32'(req_ready), 0);
        check("midwait_rsp_valid", 32'(rsp_valid), 0);
        check("midwait_ss", 32'(spi_ss), 0);
        check("midwait_rsp_data", 32'(rsp_data), 0);
        rst = 1'b0;
        req_valid = '0;
        spi_done = 1'b1;
        spi_rx = 8'hEE;
        @(negedge clk);
        spi_done = 1'b0;
        seen = 0;
        repeat (3) begin
            seen = seen | int'(rsp_valid);
            @(negedge clk);
        end
        check("late_done_ignored", 32'(seen), 0);
        req_valid = 4'b0011;
        serve(2, 8'h71, who, tx, ss);
        check("ptr_reset_who", 32'(who), 0);
        req_valid = '0;

        @(negedge clk);
        spi_done = 1'b1;
        spi_rx = 8'h99;
        @(negedge clk);
        spi_done = 1'b0;
        seen = 0;
        repeat (3) begin
            seen = seen | int'(rsp_valid);
            @(negedge clk);
        end
        check("stray_done", 32'(seen), 0);
        check("stray_done_data", 32'(rsp_data), 'h71);

`ifdef SPI_ARB_TIMEOUT_EN
        req_valid = 4'b0001;
        n = 0;
        while (!spi_start && n < 20) begin
            @(negedge clk);
            n++;
        end
        req_valid = '0;
        n = 0;
        while (rsp_valid == '0 && n < 40) begin
            @(negedge clk);
            n++;
        end
        check("to_rsp_seen", 32'(n < 40), 1);
        check("to_not_early", 32'(n >= TO), 1);
        check("to_rsp_valid", 32'(rsp_valid), 'b0001);
        check("to_err", 32'(rsp_err), 1);
        check("to_data", 32'(rsp_data), 'hFF);
`endif

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule
